// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the piso readout sequencer: FSM encoding and output buffer depth.
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int OBUF_DEPTH = 32'd2;

endpackage

// File: rtl/piso_readout_ctrl_chk.sv
// Runtime checks for the readout sequencer's output buffer.
module obuf2_chk
  import piso_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == 2'(OBUF_DEPTH))));

endmodule

// File: rtl/piso_readout_ctrl_obuf2.sv
// Two-entry synchronous FIFO with a registered head word; a simultaneous push and pop is allowed.
module obuf2
  import piso_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic [W-1:0] w_head_nxt;
  logic [W-1:0] w_tail_nxt;
  logic [1:0]   w_count_nxt;
  logic         w_pop;

  // Next-state of the storage; an emptied slot is zeroed so the head reads 0 when empty.
  always_comb begin
    w_pop       = pop && (r_count != 2'd0);
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush) begin
      w_head_nxt  = {W{1'b0}};
      w_tail_nxt  = {W{1'b0}};
      w_count_nxt = 2'd0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_head_nxt  = din;
            w_count_nxt = 2'd1;
          end else if (r_count == 2'd1) begin
            w_tail_nxt  = din;
            w_count_nxt = 2'd2;
          end else begin
            w_count_nxt = r_count;
          end
        end
        2'b01: begin
          w_head_nxt  = r_tail;
          w_tail_nxt  = {W{1'b0}};
          w_count_nxt = r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            w_head_nxt = din;
          end else begin
            w_head_nxt = r_tail;
            w_tail_nxt = din;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= {W{1'b0}};
      r_tail  <= {W{1'b0}};
      r_count <= 2'd0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign dout  = r_head;
  assign count = r_count;

endmodule

// File: rtl/piso_readout_ctrl.sv
// Streams words 0..n-1 of a piso bank onto a valid/ready port, hiding the one-cycle read
// latency and downstream backpressure behind a 2-entry output buffer.
module piso_readout_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = $clog2(N_REG),
  parameter int CNT_BITS     = $clog2(N_REG + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_BITS-1:0]     n_words,
  output logic                    piso_read,
  output logic [N_REG_BITS-1:0]   piso_addr,
  input  logic [R_DATA_WIDTH-1:0] piso_dout,
  output logic [R_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CNT_BITS-1:0] N_REG_C = CNT_BITS'(N_REG);
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1'b1);
  localparam logic [CNT_BITS-1:0] ZERO_C  = {CNT_BITS{1'b0}};

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_BITS-1:0] r_n_q;
  logic [CNT_BITS-1:0] r_iss_cnt;
  logic [CNT_BITS-1:0] r_pop_cnt;
  logic                r_pending;
  logic                r_done;
  logic [CNT_BITS-1:0] w_n_clamp;
  logic [CNT_BITS-1:0] w_last_idx;
  logic [1:0]          w_fifo_count;
  logic [2:0]          w_occ;
  logic                w_out_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic                w_last_pop;
  logic                w_start_idle;

  // Issue only while reads in flight plus buffered words, net of this cycle's pop, leave room.
  always_comb begin
    w_n_clamp    = (n_words > N_REG_C) ? N_REG_C : n_words;
    w_last_idx   = r_n_q - ONE_C;
    w_out_valid  = (w_fifo_count != 2'd0);
    w_pop        = w_out_valid && out_ready;
    w_last_pop   = w_pop && (r_pop_cnt == w_last_idx);
    w_occ        = {1'b0, w_fifo_count} + {2'b00, r_pending} - {2'b00, w_pop};
    w_issue      = (r_state == ST_RUN) && !abort && (r_iss_cnt < r_n_q) && (w_occ < 3'd2);
    w_push       = r_pending && !abort;
    w_start_idle = (r_state == ST_IDLE) && start && !abort;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state; abort wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && (n_words != ZERO_C)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_issue && ((r_iss_cnt + ONE_C) == r_n_q)) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (w_last_pop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    piso_read = w_issue;
    if (w_issue) begin
      piso_addr = r_iss_cnt[N_REG_BITS-1:0];
    end else begin
      piso_addr = {N_REG_BITS{1'b0}};
    end
    busy      = (r_state != ST_IDLE);
    out_valid = w_out_valid;
    out_last  = w_out_valid && (r_pop_cnt == w_last_idx);
    done      = r_done;
  end

  // Counters, in-flight read flag and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_q     <= ZERO_C;
      r_iss_cnt <= ZERO_C;
      r_pop_cnt <= ZERO_C;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else if (abort) begin
      r_iss_cnt <= ZERO_C;
      r_pop_cnt <= ZERO_C;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pending <= w_issue;
      r_done    <= (w_start_idle && (n_words == ZERO_C)) ||
                   ((r_state == ST_DRAIN) && w_last_pop);
      if (w_start_idle) begin
        r_n_q     <= w_n_clamp;
        r_iss_cnt <= ZERO_C;
        r_pop_cnt <= ZERO_C;
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + ONE_C;
        end
        if (w_pop) begin
          r_pop_cnt <= r_pop_cnt + ONE_C;
        end
      end
    end
  end

  obuf2 #(
    .W(R_DATA_WIDTH)
  ) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .flush(abort),
    .push (w_push),
    .pop  (w_pop),
    .din  (piso_dout),
    .dout (out_data),
    .count(w_fifo_count)
  );

  obuf2_chk u_obuf_chk (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .count(w_fifo_count)
  );

endmodule

// File: doc/piso_readout_ctrl.md
Name: piso_readout_ctrl

Overview:
Sequencer that drains a `piso` word bank onto a valid/ready output stream. On `start` it issues `read`/`addr` to the `piso` for words 0..n-1 in ascending order. It absorbs the one-cycle `piso` read latency and downstream backpressure with a 2-entry output buffer. It sits between the EdDSA/RSA result registers and the AXI-side readout logic, replacing software-driven address polling.

Parameters:
- R_DATA_WIDTH, 32: word width; must match the `piso` instance.
- N_REG, 8: number of words in the `piso` bank.
- N_REG_BITS, $clog2(N_REG): `piso` address width.
- CNT_BITS, $clog2(N_REG+1): word-count width.

Ports:
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle request to begin a readout; ignored while `busy`.
- abort  in  1: synchronous abort; flushes and returns to IDLE.
- n_words  in  CNT_BITS: words to stream, sampled with `start`.
- piso_read  out  1: drives `piso.read`.
- piso_addr  out  N_REG_BITS: drives `piso.addr`.
- piso_dout  in  R_DATA_WIDTH: from `piso.dout`; valid one cycle after `piso_read`.
- out_data  out  R_DATA_WIDTH: stream data (buffer head).
- out_valid  out  1: stream valid.
- out_last  out  1: high with the final word of a readout.
- out_ready  in  1: stream ready; a pop is `out_valid & out_ready`.
- busy  out  1: readout in progress.
- done  out  1: one-cycle pulse after the last word pops.

Behaviour:
- Reset (async, any state): FSM=IDLE; counters, buffer and pending flag cleared. All outputs are 0, including `out_data`, `piso_addr`, `piso_read`, `done` and `busy`.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start`:
  - `n_q` = min(`n_words`, N_REG); `iss_cnt`=0; `pop_cnt`=0; `busy`=1 from the next cycle.
  - If `n_words`=0: stay IDLE, pulse `done` next cycle, no reads, `busy` stays 0.
- RUN, issue condition: `iss_cnt < n_q` and (`fifo_count` + `pending` − `pop`) < 2.
- RUN, on issue:
  - `piso_read`=1 and `piso_addr`=`iss_cnt` in that cycle (combinational from registered state).
  - `pending` set for the next cycle; `iss_cnt`++.
- RUN, when `pending`=1: `piso_dout` is pushed into the buffer at the clock edge ending that cycle.
- RUN -> DRAIN when the final issue occurs (`iss_cnt` reaches `n_q`).
- DRAIN: no issues; `piso_read`=0.
- DRAIN -> IDLE on the pop of the word with `pop_cnt` = `n_q`−1. `done`=1 for exactly the following cycle; `busy` drops in that same cycle.
- Buffer: 2-entry FIFO; push and pop in the same cycle are allowed. The issue rule guarantees no overflow; pushing while full is an assertion failure.
- `out_last` = `out_valid` and (`pop_cnt` = `n_q`−1).
- Latency: `start` at edge E0, `piso_read` during cycle E0–E1, data pushed at E2, so `out_valid` is high after E2.
- Throughput: 1 word/cycle with `out_ready` held at 1.
- Backpressure:
  - With `out_ready`=0, at most 2 reads are outstanding or buffered, then issue stalls.
  - `out_data`/`out_valid` remain stable until popped.
- `start` while `busy`: ignored, no effect on the current readout.
- `abort`, which has priority over `start` in the same cycle:
  - Next cycle: IDLE, buffer and pending flag flushed, `out_valid`=0.
  - No `done` pulse; an in-flight `piso` read result is discarded.
- Address never exceeds N_REG−1; no wrap-around.

Decomposition:
- Shared package `piso_ctrl_pkg`: FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the buffer depth constant OBUF_DEPTH=2.
- One sub-module: `obuf2`, the 2-entry synchronous FIFO. It has `push`/`pop`/`din`/`dout`/`count`, async active-high reset, and a registered head.
- The FSM, issue logic and counters stay in the top level.

Test Plan:
- Reset mid-RUN: N_REG=8, `din` word k = 32'hA0+k, `start` with `n_words`=8, assert `rst` on cycle 4 -> all outputs 0 immediately; no `done`; IDLE after release.
- Full stream: same data, `out_ready`=1 -> `out_valid` first high 3 cycles after `start`; `out_data` A0..A7 on consecutive cycles; `out_last` with A7; `done` 1 cycle later; `busy` high for 10 cycles.
- Backpressure: `n_words`=5, `out_ready` toggling 1,0,0,1,... -> words A0..A4 in order, none duplicated or lost; `piso_read` never issued with 2 words held.
- Clamp and zero: `n_words`=12 -> exactly 8 words, `out_last` on A7. `n_words`=0 -> `done` pulse next cycle, `piso_read` never 1.
- Abort: `start` with `n_words`=8, `abort` after 3 pops -> `out_valid`=0 next cycle, no `done`. A following `start` with `n_words`=2 streams A0, A1.
- `start` while busy: second `start` mid-stream with `n_words`=1 -> ignored; original 8-word stream completes unchanged.
